// File: rtl/dsp_pkg.sv
// Shared definitions for the MAC pipeline: post-op encodings and saturation limits.
// Latency: none (constants and elaboration-time helpers only).
// Backpressure: not applicable.
package dsp_pkg;

  // Post-op select, carried in op[1:0]
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_MSU  = 2'b10;
  localparam logic [1:0] OP_MULC = 2'b11;

  // op[OP_PRE_BIT] routes D + B into the multiplier instead of B
  localparam int OP_PRE_BIT = 2;

  // Widest accumulator the helpers can describe; callers slice the low w bits
  localparam int SAT_MAXW = 256;

  // Largest positive two's-complement value of width w, in the low w bits
  function automatic logic [SAT_MAXW-1:0] sat_max(input int w);
    return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
  endfunction

  // Most negative two's-complement value of width w, in the low w bits
  function automatic logic [SAT_MAXW-1:0] sat_min(input int w);
    return SAT_MAXW'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with clock enable and synchronous active-low reset.
// Latency: 1 cycle, or 0 when BYPASS is non-zero.
// Backpressure: ce low holds the stored value; there is no ready handshake.
module pipe_reg #(
  parameter int WIDTH  = 1,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (BYPASS != 0) begin : g_bypass
      assign q = d;
    end else begin : g_reg
      // Capture on enabled cycles; reset wins over ce
      always_ff @(posedge clk) begin
        if (!rst_n)  q <= '0;
        else if (ce) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_pipe.sv
// Signed pipelined MAC with pre-adder, framed accumulation, saturation and pattern detect.
// Latency: 2+MREG enabled cycles from in_valid to p_valid; one sample per enabled cycle.
// Backpressure: none; ce low freezes every register, valid bits included.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int              AW       = 18,
  parameter int              BW       = 18,
  parameter int              PW       = 48,
  parameter int              MREG     = 1,
  parameter int              SATURATE = 1,
  parameter logic [PW-1:0]   PATTERN  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [2:0]    op,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] d,
  input  logic [PW-1:0] c,
  output logic [PW-1:0] p,
  output logic          p_valid,
  output logic          p_last,
  output logic          ovf,
  output logic          pat_det
);

  localparam int PRW = AW + BW + 1;            // multiplier product width
  localparam int S0W = 2 + 3 + AW + 2*BW + PW; // stage 0 payload
  localparam int M1W = 2 + 2 + PW + PRW;       // multiplier stage payload

  localparam logic [SAT_MAXW-1:0] SAT_MAX_W = sat_max(PW);
  localparam logic [SAT_MAXW-1:0] SAT_MIN_W = sat_min(PW);
  localparam logic [PW-1:0]       SAT_MAX   = SAT_MAX_W[PW-1:0];
  localparam logic [PW-1:0]       SAT_MIN   = SAT_MIN_W[PW-1:0];

  // ---------------- stage 0: input capture ----------------
  logic [S0W-1:0]        s0_q;
  logic                  s0_valid, s0_last;
  logic [2:0]            s0_op;
  logic signed [AW-1:0]  s0_a;
  logic signed [BW-1:0]  s0_b, s0_d;
  logic [PW-1:0]         s0_c;

  pipe_reg #(.WIDTH(S0W), .BYPASS(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .d({in_valid, in_last, op, a, b, d, c}),
    .q(s0_q)
  );
  assign {s0_valid, s0_last, s0_op, s0_a, s0_b, s0_d, s0_c} = s0_q;

  // Pre-adder at BW+1 bits cannot overflow; product sized to its exact range
  logic signed [BW:0]    b_ext, d_ext, bb;
  logic signed [PRW-1:0] a_mx, bb_mx, pr;

  assign b_ext = {s0_b[BW-1], s0_b};
  assign d_ext = {s0_d[BW-1], s0_d};
  assign bb    = s0_op[OP_PRE_BIT] ? (d_ext + b_ext) : b_ext;
  assign a_mx  = {{(BW+1){s0_a[AW-1]}}, s0_a};
  assign bb_mx = {{AW{bb[BW]}}, bb};
  assign pr    = a_mx * bb_mx;

  // ---------------- stage 1: optional multiplier register ----------------
  logic [M1W-1:0]        m_q;
  logic                  m_valid, m_last;
  logic [1:0]            m_op;
  logic [PW-1:0]         m_c;
  logic [PRW-1:0]        m_pr;

  pipe_reg #(.WIDTH(M1W), .BYPASS(MREG == 0 ? 1 : 0)) u_m1 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .d({s0_valid, s0_last, s0_op[1:0], s0_c, pr}),
    .q(m_q)
  );
  assign {m_valid, m_last, m_op, m_c, m_pr} = m_q;

  // ---------------- P stage: post-op, overflow, saturation ----------------
  logic              first_q;
  logic signed [PW:0] pr_x, acc_x, c_x, sum;
  logic              ovf_nxt;
  logic [PW-1:0]     p_nxt;

  assign pr_x  = {{(PW+1-PRW){m_pr[PRW-1]}}, m_pr};
  assign acc_x = first_q ? '0 : {p[PW-1], p};
  assign c_x   = {m_c[PW-1], m_c};

  // One extra bit of headroom so overflow shows up as disagreeing top bits
  always_comb begin
    sum = pr_x;
    case (m_op)
      OP_MUL:  sum = pr_x;
      OP_MAC:  sum = acc_x + pr_x;
      OP_MSU:  sum = acc_x - pr_x;
      default: sum = c_x + pr_x;
    endcase
  end

  assign ovf_nxt = sum[PW] ^ sum[PW-1];
  assign p_nxt   = (ovf_nxt && (SATURATE != 0)) ? (sum[PW] ? SAT_MIN : SAT_MAX)
                                                : sum[PW-1:0];

  // Result registers update only on valid samples; first_q tracks frame starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      ovf     <= 1'b0;
      pat_det <= 1'b0;
      first_q <= 1'b1;
    end else if (ce) begin
      p_valid <= m_valid;
      if (m_valid) begin
        p       <= p_nxt;
        p_last  <= m_last;
        ovf     <= ovf_nxt;
        pat_det <= (p_nxt == PATTERN);
        first_q <= m_last;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: a saturating instance (PATTERN=42) and a wrapping twin share stimulus.
// Results are collected on enabled clock edges and compared against hand-computed values.
// Back-to-back streams, stalls and mid-frame reset are exercised.
module tb_dsp_mac_pipe;

  localparam int AW = 18, BW = 18, PW = 48;
  localparam logic [2:0] T_MUL = 3'b000, T_MAC = 3'b001, T_MSU = 3'b010, T_MULC = 3'b011;
  localparam logic [2:0] T_MUL_PRE = 3'b100, T_MAC_PRE = 3'b101;
  localparam longint PROD = 64'sd17179607041; // (2^17-1)^2

  logic          clk = 1'b0;
  logic          rst_n, ce, in_valid, in_last;
  logic [2:0]    op;
  logic [AW-1:0] a;
  logic [BW-1:0] b, d;
  logic [PW-1:0] c;
  logic [PW-1:0] p, p_w;
  logic          p_valid, p_last, ovf, pat_det;
  logic          p_valid_w, p_last_w, ovf_w, pat_det_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MREG(1), .SATURATE(1), .PATTERN(48'd42)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .op(op), .a(a), .b(b), .d(d), .c(c),
    .p(p), .p_valid(p_valid), .p_last(p_last), .ovf(ovf), .pat_det(pat_det)
  );

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .MREG(1), .SATURATE(0), .PATTERN(48'd42)) dut_w (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .op(op), .a(a), .b(b), .d(d), .c(c),
    .p(p_w), .p_valid(p_valid_w), .p_last(p_last_w), .ovf(ovf_w), .pat_det(pat_det_w)
  );

  // Result collector: one entry per enabled edge on which p_valid is seen
  typedef struct {
    logic [PW-1:0] p, p_w;
    logic          ovf, ovf_w, last, pat;
    int            stamp;
  } res_t;

  res_t rq[$];
  int   en_cnt = 0;
  logic ce_e;

  always begin
    @(posedge clk);
    ce_e = ce;
    if (ce_e === 1'b1) en_cnt++;
    #1;
    if (ce_e === 1'b1 && p_valid === 1'b1)
      rq.push_back('{p, p_w, ovf, ovf_w, p_last, pat_det, en_cnt});
  end

  function automatic res_t pop_res();
    res_t r;
    r.p = 'x; r.p_w = 'x; r.ovf = 1'bx; r.ovf_w = 1'bx; r.last = 1'bx; r.pat = 1'bx;
    r.stamp = -100;
    if (rq.size() > 0) r = rq.pop_front();
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic l, input logic [2:0] o,
                     input int av, input int bv, input int dv, input longint cv);
    in_valid = v; in_last = l; op = o;
    a = AW'(av); b = BW'(bv); d = BW'(dv); c = PW'(cv);
  endtask

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    int         a, b, dd;
    longint     cc;
    logic       last;
    longint     ep;
    logic       epat;
  } vec_t;

  localparam int NV = 13;
  vec_t tv[NV];

  initial begin
    res_t r;
    int   st[4];
    int   nerr;
    int   fa[4], fb[4];
    longint fe[4];

    // Frame: 10, 31, 27, then new frame 1; pre-adder 42; MULC 84; MSU; MUL/MULC clear frame start
    tv[0]  = '{T_MAC,     2,  5,  0,     0, 1'b0,   10, 1'b0};
    tv[1]  = '{T_MAC,     3,  7,  0,     0, 1'b0,   31, 1'b0};
    tv[2]  = '{T_MAC,    -1,  4,  0,     0, 1'b1,   27, 1'b0};
    tv[3]  = '{T_MAC,     1,  1,  0,     0, 1'b1,    1, 1'b0};
    tv[4]  = '{T_MAC_PRE, 6, -3, 10,     0, 1'b1,   42, 1'b1};
    tv[5]  = '{T_MULC,   -2,  8,  0,   100, 1'b1,   84, 1'b0};
    tv[6]  = '{T_MSU,     3,  4,  0,     0, 1'b0,  -12, 1'b0};
    tv[7]  = '{T_MSU,     1,  2,  0,     0, 1'b1,  -14, 1'b0};
    tv[8]  = '{T_MAC_PRE,-5, -4, -3,     0, 1'b1,   35, 1'b0};
    tv[9]  = '{T_MUL_PRE, 7,  2,  4,     0, 1'b0,   42, 1'b1};
    tv[10] = '{T_MAC,     1,  2,  0,     0, 1'b1,   44, 1'b0};
    tv[11] = '{T_MULC,   10, 10,  0, -1000, 1'b0, -900, 1'b0};
    tv[12] = '{T_MAC,     1,  1,  0,     0, 1'b1, -899, 1'b0};

    fa = '{2, 3, -1, 4};
    fb = '{5, 7, 4, -2};
    fe = '{10, 31, 27, 19};

    // ---------------- reset state and latency ----------------
    rst_n = 1'b0; ce = 1'b1;
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
    chk("rst_p",       $signed(p), 0);
    chk("rst_p_valid", p_valid, 0);
    chk("rst_p_last",  p_last, 0);
    chk("rst_ovf",     ovf, 0);
    chk("rst_pat_det", pat_det, 0);

    drv(1, 1, T_MUL, 3, -4, 0, 0);
    step();
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    chk("lat_edge1_valid", p_valid, 0);
    step();
    chk("lat_edge2_valid", p_valid, 0);
    step();
    chk("lat_edge3_valid", p_valid, 1);
    chk("mul_p",           $signed(p), -12);
    chk("mul_last",        p_last, 1);
    chk("mul_pat",         pat_det, 0);
    step();
    chk("idle_valid",      p_valid, 0);
    chk("idle_p_hold",     $signed(p), -12);
    rq.delete();

    // ---------------- table: back-to-back stream ----------------
    for (int i = 0; i < NV; i++) begin
      drv(1, tv[i].last, tv[i].op, tv[i].a, tv[i].b, tv[i].dd, tv[i].cc);
      step();
    end
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    repeat (4) step();
    chk("tbl_count", rq.size(), NV);
    for (int i = 0; i < NV; i++) begin
      r = pop_res();
      chk($sformatf("tbl%0d_p", i),    $signed(r.p),   tv[i].ep);
      chk($sformatf("tbl%0d_pw", i),   $signed(r.p_w), tv[i].ep);
      chk($sformatf("tbl%0d_last", i), r.last,         tv[i].last);
      chk($sformatf("tbl%0d_pat", i),  r.pat,          tv[i].epat);
      chk($sformatf("tbl%0d_ovf", i),  r.ovf,          0);
    end

    // ---------------- saturation vs wrap ----------------
    for (int k = 1; k <= 8193; k++) begin
      drv(1, 0, T_MAC, 131071, 131071, 0, 0);
      step();
    end
    drv(1, 1, T_MSU, 1, 1, 0, 0);
    step();
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    repeat (4) step();
    chk("sat_count", rq.size(), 8194);
    nerr = 0;
    for (int k = 1; k <= 8192; k++) begin
      r = pop_res();
      if ($signed(r.p) != longint'(k) * PROD || $signed(r.p_w) != longint'(k) * PROD ||
          r.ovf !== 1'b0 || r.ovf_w !== 1'b0)
        nerr++;
    end
    chk("sat_ramp_errors", nerr, 0);
    r = pop_res();
    chk("sat_p_max",    $signed(r.p),   64'sd140737488355327);
    chk("sat_ovf",      r.ovf,          1);
    chk("wrap_p",       $signed(r.p_w), -64'sd140722456223743);
    chk("wrap_ovf",     r.ovf_w,        1);
    r = pop_res();
    chk("sat_after_p",   $signed(r.p),   64'sd140737488355326);
    chk("sat_after_ovf", r.ovf,          0);
    chk("wrap_after_p",  $signed(r.p_w), -64'sd140722456223744);
    chk("wrap_after_ovf", r.ovf_w,       0);

    // ---------------- 4-sample frame, CE high ----------------
    for (int i = 0; i < 4; i++) begin
      drv(1, i == 3, T_MAC, fa[i], fb[i], 0, 0);
      step();
      st[i] = en_cnt;
    end
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    repeat (4) step();
    chk("ce1_count", rq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      r = pop_res();
      chk($sformatf("ce1_p%0d", i),   $signed(r.p), fe[i]);
      chk($sformatf("ce1_lat%0d", i), r.stamp - st[i], 2);
    end

    // ---------------- same frame, CE toggling ----------------
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1;
      drv(1, i == 3, T_MAC, fa[i], fb[i], 0, 0);
      step();
      st[i] = en_cnt;
      ce = 1'b0;
      step();
    end
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      ce = (i % 2 == 0);
      step();
    end
    ce = 1'b1;
    chk("ce_tog_count", rq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      r = pop_res();
      chk($sformatf("ce_tog_p%0d", i),   $signed(r.p), fe[i]);
      chk($sformatf("ce_tog_lat%0d", i), r.stamp - st[i], 2);
    end

    // ---------------- reset mid-frame with two samples in flight ----------------
    drv(1, 0, T_MAC, 1, 1, 0, 0); step();
    drv(1, 0, T_MAC, 2, 5, 0, 0); step();
    drv(1, 0, T_MAC, 3, 7, 0, 0); step();
    chk("pre_rst_p", $signed(p), 1);
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_p",       $signed(p), 0);
    chk("mid_rst_valid",   p_valid, 0);
    chk("mid_rst_last",    p_last, 0);
    chk("mid_rst_ovf",     ovf, 0);
    chk("mid_rst_pat",     pat_det, 0);
    repeat (4) step();
    chk("mid_rst_no_stray", rq.size(), 1);
    r = pop_res();
    chk("mid_rst_before_p", $signed(r.p), 1);
    drv(1, 1, T_MAC, 2, 5, 0, 0); step();
    drv(0, 0, T_MUL, 0, 0, 0, 0);
    repeat (4) step();
    chk("post_rst_count", rq.size(), 1);
    r = pop_res();
    chk("post_rst_p",    $signed(r.p), 10);
    chk("post_rst_last", r.last, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
